// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - SRAM-like request/response port bundle
interface mem_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Issuer of requests: drives the request fields, receives handshakes.
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Acceptor of requests: receives the request fields, drives handshakes.
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - fetch/load-store arbiter onto one SRAM-like port
module mem_req_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.slave  inst_sram,
  mem_req_arbiter_if.slave  data_sram,
  mem_req_arbiter_if.master mem,
  output logic              protocol_err
);
  localparam int               PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

  typedef enum logic { OWN_INST = 1'b0, OWN_DATA = 1'b1 } owner_e;

  owner_e               grant;
  owner_e               lock_owner;
  owner_e               head;
  logic                 lock_valid;
  logic                 full;
  logic                 sel_req;
  logic                 accept;
  logic                 pop;
  logic [CNT_W-1:0]     cnt;
  logic [PTR_W-1:0]     rptr;
  logic [PTR_W-1:0]     wptr;
  logic [MAX_OUTST-1:0] owner_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Pick the granted requester (a pending lock wins, else data over fetch) and mux its fields out.
  always_comb begin
    grant = OWN_INST;
    if (lock_valid)         grant = lock_owner;
    else if (data_sram.req) grant = OWN_DATA;
    full    = (cnt == CNT_FULL);
    sel_req = (grant == OWN_DATA) ? data_sram.req : inst_sram.req;
    // Full blocks issue outright; a same-cycle pop does not reopen the slot, keeping mem_data_ok off the mem_req path.
    mem.req   = !full && sel_req;
    mem.wr    = (grant == OWN_DATA) ? data_sram.wr    : inst_sram.wr;
    mem.size  = (grant == OWN_DATA) ? data_sram.size  : inst_sram.size;
    mem.addr  = (grant == OWN_DATA) ? data_sram.addr  : inst_sram.addr;
    mem.wstrb = (grant == OWN_DATA) ? data_sram.wstrb : inst_sram.wstrb;
    mem.wdata = (grant == OWN_DATA) ? data_sram.wdata : inst_sram.wdata;
  end

  // Address handshakes go to the granted side only; responses go to the owner at the FIFO head.
  always_comb begin
    accept            = mem.req && mem.addr_ok;
    pop               = mem.data_ok && (cnt != '0);
    head              = owner_e'(owner_q[rptr]);
    inst_sram.addr_ok = accept && (grant == OWN_INST);
    data_sram.addr_ok = accept && (grant == OWN_DATA);
    inst_sram.data_ok = pop && (head == OWN_INST);
    data_sram.data_ok = pop && (head == OWN_DATA);
    inst_sram.rdata   = mem.rdata;
    data_sram.rdata   = mem.rdata;
  end

  // In-order owner FIFO: record who issued each accepted address, retire one per response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        owner_q[wptr] <= logic'(grant);
        wptr          <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      if (accept && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!accept && pop) cnt <= cnt - CNT_W'(1);
    end
  end

  // Hold the grant on a requester whose address is not yet taken; release on accept or if it withdraws.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= OWN_INST;
    end else if (accept) begin
      lock_valid <= 1'b0;
    end else if (mem.req) begin
      lock_valid <= 1'b1;
      lock_owner <= grant;
    end else if (lock_valid && !sel_req) begin
      lock_valid <= 1'b0;
    end
  end

  // Sticky flag for a response that has no outstanding transaction to belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         protocol_err <= 1'b0;
    else if (mem.data_ok && cnt == '0) protocol_err <= 1'b1;
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  logic clk;
  logic reset;
  logic protocol_err;
  int   n_cmp;
  int   n_err;

  mem_req_arbiter_if inst_if ();
  mem_req_arbiter_if data_if ();
  mem_req_arbiter_if mem_if ();

  mem_req_arbiter #(.MAX_OUTST(2), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_sram    (inst_if),
    .data_sram    (data_if),
    .mem          (mem_if),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.addr = 0; inst_if.wstrb = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.addr = 0; data_if.wstrb = 0; data_if.wdata = 0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    #2;
    n_cmp++; if (mem_if.req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", mem_if.req); end
    n_cmp++; if ({inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 4'b0)
      begin n_err++; $display("FAIL rst_handshakes got %b want 0000", {inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok}); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL rst_protocol_err got %b want 0", protocol_err); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    inst_if.req = 1; inst_if.addr = 32'h1c000000;
    data_if.req = 1; data_if.addr = 32'h80; data_if.wr = 1; data_if.wstrb = 4'hf; data_if.wdata = 32'hdeadbeef;
    mem_if.addr_ok = 1;
    #2;
    n_cmp++; if (mem_if.addr !== 32'h80) begin n_err++; $display("FAIL sim_addr got %h want 00000080", mem_if.addr); end
    n_cmp++; if ({mem_if.wr, mem_if.wstrb} !== 5'b1_1111) begin n_err++; $display("FAIL sim_wr_wstrb got %b want 11111", {mem_if.wr, mem_if.wstrb}); end
    n_cmp++; if ({data_if.addr_ok, inst_if.addr_ok} !== 2'b10) begin n_err++; $display("FAIL sim_addr_ok got %b want 10", {data_if.addr_ok, inst_if.addr_ok}); end
    tick();
    data_if.req = 0; data_if.wr = 0; data_if.wstrb = 0;
    #2;
    n_cmp++; if (mem_if.addr !== 32'h1c000000) begin n_err++; $display("FAIL sim_inst_addr got %h want 1c000000", mem_if.addr); end
    n_cmp++; if ({data_if.addr_ok, inst_if.addr_ok} !== 2'b01) begin n_err++; $display("FAIL sim_inst_addr_ok got %b want 01", {data_if.addr_ok, inst_if.addr_ok}); end
    tick();
    clear_inputs();
    mem_if.data_ok = 1; mem_if.rdata = 32'haaaa0001;
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b10) begin n_err++; $display("FAIL sim_resp0_owner got %b want 10", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    mem_if.rdata = 32'haaaa0002;
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b01) begin n_err++; $display("FAIL sim_resp1_owner got %b want 01", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_lock_hold();
    inst_if.req = 1; inst_if.addr = 32'h1c000000;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_if.req = 1; data_if.addr = 32'h80; end
      #2;
      n_cmp++; if (mem_if.addr !== 32'h1c000000) begin n_err++; $display("FAIL lock_addr_c%0d got %h want 1c000000", c, mem_if.addr); end
      n_cmp++; if ({data_if.addr_ok, inst_if.addr_ok} !== 2'b00) begin n_err++; $display("FAIL lock_addr_ok_c%0d got %b want 00", c, {data_if.addr_ok, inst_if.addr_ok}); end
      tick();
    end
    mem_if.addr_ok = 1;
    #2;
    n_cmp++; if (mem_if.addr !== 32'h1c000000) begin n_err++; $display("FAIL lock_accept_addr got %h want 1c000000", mem_if.addr); end
    n_cmp++; if ({data_if.addr_ok, inst_if.addr_ok} !== 2'b01) begin n_err++; $display("FAIL lock_accept_ok got %b want 01", {data_if.addr_ok, inst_if.addr_ok}); end
    tick();
    inst_if.req = 0;
    #2;
    n_cmp++; if ({mem_if.addr, data_if.addr_ok} !== {32'h80, 1'b1}) begin n_err++; $display("FAIL lock_data_next got %h/%b want 00000080/1", mem_if.addr, data_if.addr_ok); end
    tick();
    clear_inputs();
    mem_if.data_ok = 1;
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b01) begin n_err++; $display("FAIL lock_drain0 got %b want 01", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b10) begin n_err++; $display("FAIL lock_drain1 got %b want 10", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_in_order();
    inst_if.req = 1; inst_if.addr = 32'h1c000010; mem_if.addr_ok = 1;
    tick();
    inst_if.req = 0; data_if.req = 1; data_if.addr = 32'h100;
    tick();
    clear_inputs();
    mem_if.data_ok = 1; mem_if.rdata = 32'h11111111;
    #2;
    n_cmp++; if ({inst_if.data_ok, data_if.data_ok, inst_if.rdata} !== {2'b10, 32'h11111111})
      begin n_err++; $display("FAIL order_first got %b%b/%h want 10/11111111", inst_if.data_ok, data_if.data_ok, inst_if.rdata); end
    tick();
    mem_if.rdata = 32'h22222222;
    #2;
    n_cmp++; if ({inst_if.data_ok, data_if.data_ok, data_if.rdata} !== {2'b01, 32'h22222222})
      begin n_err++; $display("FAIL order_second got %b%b/%h want 01/22222222", inst_if.data_ok, data_if.data_ok, data_if.rdata); end
    tick();
    clear_inputs();
    #2;
    n_cmp++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL order_cnt got %0d want 0", dut.cnt); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL order_no_err got %b want 0", protocol_err); end
  endtask

  task automatic test_full_stall();
    inst_if.req = 1; inst_if.addr = 32'h1c000020; mem_if.addr_ok = 1;
    tick();
    tick();
    data_if.req = 1; data_if.addr = 32'h200;
    #2;
    n_cmp++; if (mem_if.req !== 1'b0) begin n_err++; $display("FAIL full_mem_req got %b want 0", mem_if.req); end
    n_cmp++; if ({data_if.addr_ok, inst_if.addr_ok} !== 2'b00) begin n_err++; $display("FAIL full_addr_ok got %b want 00", {data_if.addr_ok, inst_if.addr_ok}); end
    tick();
    mem_if.data_ok = 1;
    #2;
    n_cmp++; if ({mem_if.req, data_if.addr_ok, inst_if.addr_ok} !== 3'b000) begin n_err++; $display("FAIL full_pop_no_accept got %b want 000", {mem_if.req, data_if.addr_ok, inst_if.addr_ok}); end
    n_cmp++; if (inst_if.data_ok !== 1'b1) begin n_err++; $display("FAIL full_pop_owner got %b want 1", inst_if.data_ok); end
    tick();
    mem_if.data_ok = 0;
    #2;
    n_cmp++; if ({mem_if.req, data_if.addr_ok, mem_if.addr} !== {2'b11, 32'h200}) begin n_err++; $display("FAIL full_resume got %b%b/%h want 11/00000200", mem_if.req, data_if.addr_ok, mem_if.addr); end
    tick();
    clear_inputs();
    #2;
    n_cmp++; if (dut.cnt !== 3'd2) begin n_err++; $display("FAIL full_cnt got %0d want 2", dut.cnt); end
    mem_if.data_ok = 1;
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b01) begin n_err++; $display("FAIL full_drain0 got %b want 01", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b10) begin n_err++; $display("FAIL full_drain1 got %b want 10", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_wrap();
    for (int i = 0; i <= 10; i++) begin
      clear_inputs();
      if (i < 10) begin
        mem_if.addr_ok = 1;
        if (i % 2 == 0) begin inst_if.req = 1; inst_if.addr = 32'h1000 + 32'(i * 4); end
        else            begin data_if.req = 1; data_if.addr = 32'h2000 + 32'(i * 4); end
      end
      if (i > 0) begin mem_if.data_ok = 1; mem_if.rdata = 32'hc0de0000 + 32'(i - 1); end
      #2;
      if (i < 10) begin
        n_cmp++; if ({data_if.addr_ok, inst_if.addr_ok} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
          begin n_err++; $display("FAIL wrap_accept_%0d got %b", i, {data_if.addr_ok, inst_if.addr_ok}); end
      end
      if (i > 0) begin
        n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== (((i - 1) % 2 == 0) ? 2'b01 : 2'b10))
          begin n_err++; $display("FAIL wrap_route_%0d got %b", i - 1, {data_if.data_ok, inst_if.data_ok}); end
      end
      tick();
      if (i < 10) begin
        #1;
        n_cmp++; if (dut.cnt !== 3'd1) begin n_err++; $display("FAIL wrap_cnt_%0d got %0d want 1", i, dut.cnt); end
      end
    end
    clear_inputs();
    #2;
    n_cmp++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL wrap_cnt_end got %0d want 0", dut.cnt); end
  endtask

  task automatic test_error_reset();
    mem_if.data_ok = 1;
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b00) begin n_err++; $display("FAIL err_no_data_ok got %b want 00", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    mem_if.data_ok = 0;
    #2;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", protocol_err); end
    n_cmp++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL err_cnt got %0d want 0", dut.cnt); end
    inst_if.req = 1; mem_if.addr_ok = 1;
    tick();
    tick();
    inst_if.req = 0;
    #2;
    n_cmp++; if (dut.cnt !== 3'd2) begin n_err++; $display("FAIL err_pre_rst_cnt got %0d want 2", dut.cnt); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({dut.cnt, dut.lock_valid, protocol_err} !== 5'b0)
      begin n_err++; $display("FAIL async_rst got cnt=%0d lock=%b err=%b want 0/0/0", dut.cnt, dut.lock_valid, protocol_err); end
    n_cmp++; if (mem_if.req !== 1'b0) begin n_err++; $display("FAIL async_rst_mem_req got %b want 0", mem_if.req); end
    tick();
    reset = 1'b0;
    mem_if.data_ok = 1;
    #2;
    n_cmp++; if ({data_if.data_ok, inst_if.data_ok} !== 2'b00) begin n_err++; $display("FAIL post_rst_data_ok got %b want 00", {data_if.data_ok, inst_if.data_ok}); end
    tick();
    clear_inputs();
    #2;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL post_rst_err got %b want 1", protocol_err); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_simultaneous();
    test_lock_hold();
    test_in_order();
    test_full_stall();
    test_wrap();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port (req / addr_ok / data_ok handshake) between the fetch requester (inst_sram_*) and the load/store requester (data_sram_*, driven by the EX and MEM stages).
- Forwards exactly one request per cycle, with fixed priority to data.
- Holds the grant until the address is accepted.
- Tracks outstanding transactions in an in-order owner FIFO and routes each data_ok/rdata response back to the requester that issued it.

Parameters:
- MAX_OUTST, 2: maximum accepted-but-unanswered transactions (1..4).
- CNT_W, 3: width of the outstanding counter; must hold MAX_OUTST.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_sram_req  in  1  fetch request
- inst_sram_wr  in  1  write flag (fetch always drives 0; forwarded as-is)
- inst_sram_size  in  2  0=byte, 1=half, 2=word
- inst_sram_addr  in  32  address
- inst_sram_wstrb  in  4  byte strobes
- inst_sram_wdata  in  32  write data
- inst_sram_addr_ok  out  1  fetch address accepted
- inst_sram_data_ok  out  1  fetch response valid
- inst_sram_rdata  out  32  fetch read data
- data_sram_req / wr / size / addr / wstrb / wdata  in  1/1/2/32/4/32  load/store request, same meanings as the inst_sram_* inputs
- data_sram_addr_ok  out  1  load/store address accepted
- data_sram_data_ok  out  1  load/store response valid
- data_sram_rdata  out  32  load read data
- mem_req / wr / size / addr / wstrb / wdata  out  1/1/2/32/4/32  downstream request
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream response valid (in order)
- mem_rdata  in  32  downstream read data
- protocol_err  out  1  sticky: mem_data_ok arrived with nothing outstanding

Behaviour:
- Grant selection (combinational)
  - If lock_valid=1, grant = lock_owner.
  - Otherwise, grant = DATA when data_sram_req=1, else INST.
- Stall rule
  - full = (cnt == MAX_OUTST).
  - mem_req = !full && req of the granted requester.
  - mem_wr/size/addr/wstrb/wdata are a pure mux of the granted requester's fields.
- Address handshake
  - <grant>_addr_ok = mem_req && mem_addr_ok.
  - The non-granted requester's addr_ok is 0.
- Grant lock register (lock_valid, lock_owner)
  - Set: mem_req=1 && mem_addr_ok=0 → lock_valid<=1, lock_owner<=grant. Pending request stays on the same requester even if a data request arrives.
  - Clear: accepted (mem_req && mem_addr_ok), or the locked requester drops req. Dropping req is a protocol violation; the block tolerates it and does not raise protocol_err.
  - A lock set while full persists; mem_req is re-asserted once full clears.
- Owner FIFO (MAX_OUTST entries, 1 bit each: 0=INST, 1=DATA)
  - Push: mem_req && mem_addr_ok, writes grant at wptr.
  - Pop: mem_data_ok && cnt!=0, reads rptr.
  - Pointers wrap modulo MAX_OUTST.
  - cnt: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - While full, no push occurs even if mem_data_ok pops in the same cycle. This keeps the combinational path mem_data_ok→mem_req out of the design; mem_req resumes the next cycle.
- Response routing
  - Head owner = fifo[rptr].
  - <owner>_data_ok = mem_data_ok && cnt!=0; the other requester's data_ok is 0.
  - inst_sram_rdata = data_sram_rdata = mem_rdata, unmasked; consumers qualify with data_ok.
  - Response latency through the block is 0 cycles (combinational). Address acceptance latency is 0 cycles when not full.
- Error case
  - mem_data_ok with cnt==0: no data_ok is forwarded, cnt stays 0, protocol_err<=1.
  - protocol_err clears only on reset.
- Reset (asynchronous, immediate)
  - cnt=0, rptr=wptr=0, lock_valid=0, protocol_err=0.
  - Resulting outputs: mem_req=0 unless a requester drives req; all addr_ok/data_ok=0.
  - Reset mid-transaction discards all outstanding ownership; responses arriving after reset count as protocol errors.

Test Plan:
1. Simultaneous request: inst_sram_req=1 (addr 0x1c000000) and data_sram_req=1 (addr 0x80, wr=1, wstrb=4'hf) in the same cycle, mem_addr_ok=1 → mem_addr=0x80, data_sram_addr_ok=1, inst_sram_addr_ok=0. Next cycle inst is accepted at 0x1c000000. FIFO order is DATA, INST.
2. Lock hold: inst request with mem_addr_ok=0 for 3 cycles while data_sram_req rises in cycle 2 → mem_addr stays 0x1c000000 until accepted. The data request is granted only in the following cycle.
3. In-order routing: accept inst, then data. Return mem_data_ok twice with rdata 0x11111111 then 0x22222222 → inst_sram_data_ok pulses with 0x11111111, then data_sram_data_ok pulses with 0x22222222. cnt ends at 0.
4. Full stall: MAX_OUTST=2, two accepted and unanswered requests → mem_req=0 and both addr_ok=0. In the cycle mem_data_ok arrives, still no accept. The next cycle accepts and cnt returns to 2.
5. Wrap and simultaneous events: 10 back-to-back accepts with responses lagging by 1 cycle (push+pop every cycle) → cnt stays 1 and the pointers wrap. All owners route correctly.
6. Error and reset: mem_data_ok with cnt=0 → no data_ok, protocol_err=1. Then assert reset asynchronously mid-cycle with 2 outstanding → cnt=0, lock_valid=0, protocol_err=0 immediately, without waiting for a clock edge.
